// File: rtl/divider_hs_signed.sv
// Iterative restoring divider (radix 2^STEPS), unsigned or signed per operation,
// valid/ready on both sides, defined results for divide-by-zero and MIN / -1.
module divider_hs_signed #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             overflow
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    CNT_INIT = CW'(N - 1);
  localparam logic [WIDTH-1:0] MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             negq_q, negq_d, negr_q, negr_d, ovfp_q, ovfp_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d, overflow_q, overflow_d;

  logic             accept, neg_a, neg_b;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] qq;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    // quo_q holds the remaining dividend bits on the left and the quotient bits on the right
    pr = {1'b0, prem_q};
    qq = quo_q;
    for (int unsigned i = 0; i < STEPS; i++) begin
      pr = {pr[WIDTH-1:0], qq[WIDTH-1]};
      qq = {qq[WIDTH-2:0], 1'b0};
      if (pr >= {1'b0, dmag_q}) begin
        pr    = pr - {1'b0, dmag_q};
        qq[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    prem_d      = prem_q;
    dmag_d      = dmag_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    ovfp_d      = ovfp_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;
    neg_a       = in_signed & dividend[WIDTH-1];
    neg_b       = in_signed & divisor[WIDTH-1];
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            quo_d   = neg_a ? -dividend : dividend;
            dmag_d  = neg_b ? -divisor : divisor;
            prem_d  = '0;
            negq_d  = neg_a ^ neg_b;
            negr_d  = neg_a;
            ovfp_d  = in_signed && (dividend == MIN_V) && (divisor == '1);
            cnt_d   = CNT_INIT;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        quo_d  = qq;
        prem_d = pr[WIDTH-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        quotient_d  = negq_q ? -quo_q : quo_q;
        remainder_d = negr_q ? -prem_q : prem_q;
        overflow_d  = ovfp_q;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d    = IDLE;
      div_zero_d = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      prem_q      <= '0;
      dmag_q      <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      ovfp_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      prem_q      <= prem_d;
      dmag_q      <= dmag_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      ovfp_q      <= ovfp_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_divider_hs_signed.sv
// Directed bench for divider_hs_signed: one STEPS=1 and one STEPS=4 instance, WIDTH=32.
module tb_divider_hs_signed;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fl [2];
  logic        iv [2];
  logic        rdy [2];
  logic        sgn [2];
  logic [31:0] dvd [2];
  logic [31:0] dvs [2];
  logic        ovd [2];
  logic        ordy [2];
  logic [31:0] q_o [2];
  logic [31:0] r_o [2];
  logic        dz_o [2];
  logic        ov_o [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divider_hs_signed #(.WIDTH(32), .STEPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_signed(sgn[0]), .dividend(dvd[0]), .divisor(dvs[0]), .out_valid(ovd[0]),
    .out_ready(ordy[0]), .quotient(q_o[0]), .remainder(r_o[0]), .div_zero(dz_o[0]),
    .overflow(ov_o[0]));

  divider_hs_signed #(.WIDTH(32), .STEPS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_signed(sgn[1]), .dividend(dvd[1]), .divisor(dvs[1]), .out_valid(ovd[1]),
    .out_ready(ordy[1]), .quotient(q_o[1]), .remainder(r_o[1]), .div_zero(dz_o[1]),
    .overflow(ov_o[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one operation and waits for out_valid; lat counts edges from the accept edge inclusive.
  task automatic run_op(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int n = 0;
    while (!rdy[sel] && n < 100) begin
      @(posedge clk); #1; n++;
    end
    sgn[sel] = s; dvd[sel] = a; dvs[sel] = b; iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv[sel] = 1'b0; dvd[sel] = '0; dvs[sel] = '0; sgn[sel] = 1'b0;
    lat = 1;
    while (!ovd[sel] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!ovd[sel]) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic take(input int sel);
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
  endtask

  task automatic expect_res(input int sel, input string tag, input logic [31:0] q,
                            input logic [31:0] r, input logic dz, input logic ov);
    check({tag, ".q"}, q_o[sel], q);
    check({tag, ".r"}, r_o[sel], r);
    check({tag, ".dz"}, {31'd0, dz_o[sel]}, {31'd0, dz});
    check({tag, ".ov"}, {31'd0, ov_o[sel]}, {31'd0, ov});
  endtask

  task automatic watch_quiet(input int sel, input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (ovd[sel]) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      fl[i] = 1'b0; iv[i] = 1'b0; sgn[i] = 1'b0; dvd[i] = '0; dvs[i] = '0; ordy[i] = 1'b0;
    end
    #12;
    check("rst.out_valid", {31'd0, ovd[0]}, 32'd0);
    check("rst.in_ready", {31'd0, rdy[0]}, 32'd1);
    expect_res(0, "rst", 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 1'b0, 32'd100, 32'd7, lat);
    check("u100/7.lat", lat, 34);
    expect_res(0, "u100/7", 32'd14, 32'd2, 1'b0, 1'b0);
    take(0);

    run_op(0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    expect_res(0, "s-7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    take(0);
    run_op(0, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    expect_res(0, "s7/-2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    take(0);
    run_op(0, 1'b0, 32'hFFFF_FFF9, 32'd2, lat);
    expect_res(0, "uF9/2", 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    take(0);

    run_op(0, 1'b1, 32'h0000_1234, 32'd0, lat);
    check("div0.lat", lat, 1);
    expect_res(0, "div0", 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
    take(0);

    run_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    expect_res(0, "min/-1", 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    take(0);
    run_op(0, 1'b1, 32'h8000_0000, 32'd1, lat);
    expect_res(0, "min/1", 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    take(0);

    run_op(0, 1'b0, 32'd1000, 32'd10, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold.out_valid", {31'd0, ovd[0]}, 32'd1);
      check("hold.in_ready", {31'd0, rdy[0]}, 32'd0);
      check("hold.q", q_o[0], 32'd100);
      check("hold.r", r_o[0], 32'd0);
    end
    take(0);
    check("rel.in_ready", {31'd0, rdy[0]}, 32'd1);
    check("rel.out_valid", {31'd0, ovd[0]}, 32'd0);
    run_op(0, 1'b1, 32'hFFFF_FF9C, 32'd7, lat);
    check("b2b.lat", lat, 34);
    expect_res(0, "b2b-100/7", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    take(0);

    run_op(1, 1'b0, 32'd1000, 32'd33, lat);
    check("s4.lat", lat, 10);
    expect_res(1, "s4.1000/33", 32'd30, 32'd10, 1'b0, 1'b0);
    take(1);

    sgn[1] = 1'b0; dvd[1] = 32'd500; dvs[1] = 32'd3; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    check("arst.in_ready", {31'd0, rdy[1]}, 32'd1);
    check("arst.q", q_o[1], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_quiet(1, "arst.quiet", 15);
    run_op(1, 1'b0, 32'd12345, 32'd100, lat);
    expect_res(1, "arst.next", 32'd123, 32'd45, 1'b0, 1'b0);
    take(1);

    sgn[1] = 1'b0; dvd[1] = 32'd500; dvs[1] = 32'd3; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    fl[1] = 1'b1;
    @(posedge clk); #1;
    fl[1] = 1'b0;
    check("flush.in_ready", {31'd0, rdy[1]}, 32'd1);
    watch_quiet(1, "flush.quiet", 15);

    fl[1] = 1'b1; iv[1] = 1'b1; dvd[1] = 32'd9; dvs[1] = 32'd0;
    @(posedge clk); #1;
    fl[1] = 1'b0; iv[1] = 1'b0;
    check("flushacc.in_ready", {31'd0, rdy[1]}, 32'd1);
    check("flushacc.out_valid", {31'd0, ovd[1]}, 32'd0);

    run_op(1, 1'b1, 32'hFFFF_FFCE, 32'hFFFF_FFF9, lat);
    check("flush.next.lat", lat, 10);
    expect_res(1, "flush.next", 32'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    take(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
